fwd_net: RTL



---
 rtl/fwd_net.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fwd_net.sv
// ---------------------------------------------------------------------------
// fwd_net
//
// Operand bypass network with an in-flight write tracker for the integer
// pipeline. It sits between the decode register-file read and the EX operand
// latches. Each of STAGES tracked stages after decode holds
// {valid, destination GPR, late-result flag}. For every one of NREAD read
// ports the block selects the youngest matching producer, then writeback,
// then register-file data. It raises a load-use stall when the winning
// producer's result is not yet available.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   iss_*        : instruction issuing from decode this cycle
//   hold         : freeze all tracked stages
//   flush        : kill all tracked entries and drop the issuing instruction
//   stg_data     : per-stage result bus, slice s = stg_data[s*WIDTH +: WIDTH]
//   wb_*         : writeback port
//   rd_use/addr  : per-port operand request and source GPR
//   rd_gpr       : per-port register-file read data
//   fwd_data     : per-port resolved operand (combinational)
//   stall        : decode must not issue this cycle (combinational)
//   pend_cnt     : number of valid tracked entries (registered)
// ---------------------------------------------------------------------------
module fwd_net #(
    parameter int WIDTH  = 32,
    parameter int NREAD  = 2,
    parameter int STAGES = 3,
    localparam int CW    = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iss_valid,
    input  logic                      iss_wen,
    input  logic [4:0]                iss_dst,
    input  logic                      iss_late,
    input  logic                      hold,
    input  logic                      flush,
    input  logic [STAGES*WIDTH-1:0]   stg_data,
    input  logic                      wb_we,
    input  logic [4:0]                wb_addr,
    input  logic [WIDTH-1:0]          wb_data,
    input  logic [NREAD-1:0]          rd_use,
    input  logic [NREAD*5-1:0]        rd_addr,
    input  logic [NREAD*WIDTH-1:0]    rd_gpr,
    output logic [NREAD*WIDTH-1:0]    fwd_data,
    output logic                      stall,
    output logic [CW-1:0]             pend_cnt
);

    // Population count of the valid vector.
    function automatic logic [CW-1:0] popcnt(input logic [STAGES-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            cnt = cnt + CW'(v[k]);
        end
        return cnt;
    endfunction

    logic [STAGES-1:0]       vld_r;
    logic [STAGES-1:0]       late_r;
    logic [4:0]              dst_r      [STAGES];
    logic [CW-1:0]           pend_cnt_r;

    logic [STAGES-1:0]       vld_nxt_s;
    logic [STAGES-1:0]       late_nxt_s;
    logic [4:0]              dst_nxt_s  [STAGES];
    logic [NREAD*WIDTH-1:0]  fwd_data_s;
    logic [NREAD-1:0]        port_stall_s;
    logic                    stall_s;

    // Operand selection and per-port stall detection.
    always_comb begin
        logic [4:0]       addr_s;
        logic [WIDTH-1:0] sel_s;
        logic             nrdy_s;
        logic             hit_s;
        fwd_data_s   = '0;
        port_stall_s = '0;
        addr_s       = 5'd0;
        sel_s        = '0;
        nrdy_s       = 1'b0;
        hit_s        = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            addr_s = rd_addr[i*5 +: 5];
            // Lowest-priority sources first: writeback over register file.
            sel_s  = (wb_we && (wb_addr == addr_s) && (addr_s != 5'd0))
                     ? wb_data : rd_gpr[i*WIDTH +: WIDTH];
            nrdy_s = 1'b0;
            // Walk oldest to youngest so the youngest match is applied last
            // and wins, including its readiness (an older ready copy never
            // masks a younger pending one).
            for (int s = STAGES - 1; s >= 0; s--) begin
                hit_s  = vld_r[s] && (dst_r[s] == addr_s) && (addr_s != 5'd0);
                sel_s  = hit_s ? stg_data[s*WIDTH +: WIDTH] : sel_s;
                nrdy_s = hit_s ? (late_r[s] && (s != STAGES - 1)) : nrdy_s;
            end
            fwd_data_s[i*WIDTH +: WIDTH] = sel_s;
            port_stall_s[i]              = rd_use[i] & nrdy_s;
        end
    end

    assign stall_s = |port_stall_s;

    // Next tracker contents: flush clears, hold freezes, otherwise shift.
    always_comb begin
        vld_nxt_s  = vld_r;
        late_nxt_s = late_r;
        dst_nxt_s  = dst_r;
        if (flush) begin
            vld_nxt_s = '0;
        end else if (hold) begin
            vld_nxt_s = vld_r;
        end else begin
            for (int s = STAGES - 1; s >= 1; s--) begin
                vld_nxt_s[s]  = vld_r[s-1];
                late_nxt_s[s] = late_r[s-1];
                dst_nxt_s[s]  = dst_r[s-1];
            end
            // A stalled or non-writing (incl. r0) instruction enters as a bubble.
            vld_nxt_s[0]  = iss_valid && !stall_s && iss_wen && (iss_dst != 5'd0);
            late_nxt_s[0] = iss_late;
            dst_nxt_s[0]  = iss_dst;
        end
    end

    // Tracker state and occupancy counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r      <= '0;
            late_r     <= '0;
            pend_cnt_r <= {CW{1'b0}};
            for (int s = 0; s < STAGES; s++) begin
                dst_r[s] <= 5'd0;
            end
        end else begin
            vld_r      <= vld_nxt_s;
            late_r     <= late_nxt_s;
            pend_cnt_r <= popcnt(vld_nxt_s);
            for (int s = 0; s < STAGES; s++) begin
                dst_r[s] <= dst_nxt_s[s];
            end
        end
    end

    assign fwd_data = fwd_data_s;
    assign stall    = stall_s;
    assign pend_cnt = pend_cnt_r;

endmodule
